// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every handshake and bus signal of mem_port_arbiter: the
// instruction-fetch requester (i_*), the load/store requester (d_*), the
// single-port memory (mem_*) and the two stall counters.
//
// Modports:
//   slave  - the arbiter's view (takes requests and memory responses, drives
//            done pulses, read data, memory commands and stall counters).
//   master - the surrounding system's view (requesters plus memory model).
//
// Parameters:
//   WIDTH  - data and address width in bits; must match the arbiter's WIDTH.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);

    // Instruction-fetch requester
    logic             i_req;
    logic [WIDTH-1:0] i_addr;
    logic             i_done;
    logic [WIDTH-1:0] i_rdata;

    // Load/store requester
    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_done;
    logic [WIDTH-1:0] d_rdata;

    // Unified single-port memory
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    // Stall statistics
    logic [31:0]      i_stall_cnt;
    logic [31:0]      d_stall_cnt;

    modport slave (
        input  i_req, i_addr,
        output i_done, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_done, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        output i_stall_cnt, d_stall_cnt
    );

    modport master (
        output i_req, i_addr,
        input  i_done, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_done, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        input  i_stall_cnt, d_stall_cnt
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified single-port memory between the instruction-fetch
// requester (I) and the load/store requester (D). One transaction is in
// flight at a time; the owner gets a one-cycle done pulse together with
// registered read data.
//
// Arbitration: D wins in IDLE unless I is pending and D has already been
// granted STREAK_MAX times in a row while I waited; then I is forced.
//
// Ports:
//   clk  - clock, all state updates on the rising edge.
//   rst  - asynchronous active-low reset (0 = reset).
//   bus  - mem_port_arbiter_if.slave carrying i_*, d_*, mem_* and the
//          stall counters.
//
// Parameters:
//   WIDTH      - data/address width (must match the interface WIDTH).
//   STREAK_MAX - consecutive D grants while I waits before I is forced,
//                legal range 1..15.
//
// Optional feature (macro ARB_PERF_EN):
//   defined     - i_stall_cnt / d_stall_cnt count cycles with the request
//                 high and no done pulse (32-bit, wrapping).
//   not defined - both counters are constant 0 and no flops are built.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STREAK_MAX = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

    state_t           state_q;
    state_t           state_d;
    owner_t           owner_q;
    logic [3:0]       streak_q;
    logic             grant_i;
    logic             grant_d;
    logic             force_i;

    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic [WIDTH-1:0] i_rdata_q;
    logic [WIDTH-1:0] d_rdata_q;

    // I is forced once D has used up its streak while I was waiting.
    assign force_i = bus.i_req && (streak_q == STREAK_LIM);

    // -------------------------------------------------------------------------
    // Next-state and grant decode
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Requests are only sampled here.
                if (bus.d_req && !force_i) begin
                    state_d = BUSY_D;
                    grant_d = 1'b1;
                end else if (bus.i_req) begin
                    state_d = BUSY_I;
                    grant_i = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Grant bookkeeping: owner, streak and registered memory command
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_NONE;
            streak_q    <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (grant_d) begin
                owner_q     <= OWN_D;
                mem_we_q    <= bus.d_we;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
                // Streak only grows while I is actually being held off.
                if (!bus.i_req) begin
                    streak_q <= 4'd0;
                end else if (streak_q != STREAK_LIM) begin
                    streak_q <= streak_q + 4'd1;
                end
            end else if (grant_i) begin
                owner_q     <= OWN_I;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.i_addr;
                mem_wdata_q <= '0;
                streak_q    <= 4'd0;
            end else if (state_q == RESP) begin
                owner_q     <= OWN_NONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read-data capture; each register holds between its own transactions
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (state_q == BUSY_I && bus.mem_ready) begin
                i_rdata_q <= bus.mem_rdata;
            end
            // Stores complete without touching d_rdata.
            if (state_q == BUSY_D && bus.mem_ready && !mem_we_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // -------------------------------------------------------------------------
    assign bus.mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_done    = (state_q == RESP) && (owner_q == OWN_I);
    assign bus.d_done    = (state_q == RESP) && (owner_q == OWN_D);
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    // -------------------------------------------------------------------------
    // Stall counters
    // -------------------------------------------------------------------------
`ifdef ARB_PERF_EN
    logic [31:0] i_stall_q;
    logic [31:0] d_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_stall_q <= 32'd0;
            d_stall_q <= 32'd0;
        end else begin
            if (bus.i_req && !bus.i_done) begin
                i_stall_q <= i_stall_q + 32'd1;
            end
            if (bus.d_req && !bus.d_done) begin
                d_stall_q <= d_stall_q + 32'd1;
            end
        end
    end

    assign bus.i_stall_cnt = i_stall_q;
    assign bus.d_stall_cnt = d_stall_q;
`else
    assign bus.i_stall_cnt = 32'd0;
    assign bus.d_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Cycle n is the interval after rising
// edge n; inputs are driven and outputs sampled 1 ns after each rising edge.
// A request presented in cycle 0 is granted at edge 1 (mem_req in cycle 1).
// The memory side is either driven by hand or by a small word array that
// answers in the same cycle mem_req is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int WIDTH      = 32;
    localparam int STREAK_MAX = 4;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mem_port_arbiter #(
        .WIDTH      (WIDTH),
        .STREAK_MAX (STREAK_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Memory side
    // -------------------------------------------------------------------------
    logic        auto_mem;
    logic        man_ready;
    logic [31:0] man_rdata;
    logic [31:0] mem [0:127];

    always_comb begin
        bus.mem_ready = auto_mem ? bus.mem_req : man_ready;
        bus.mem_rdata = auto_mem ? mem[bus.mem_addr[8:2]] : man_rdata;
    end

    always @(posedge clk) begin
        if (auto_mem && bus.mem_req && bus.mem_we) begin
            mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances until the selected done pulse is seen; returns the cycle it
    // appeared in, or -1 when the bound expires.
    task automatic wait_done(input bit want_d, input int max_cyc, output int cyc);
        cyc = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if ((want_d && bus.d_done) || (!want_d && bus.i_done)) begin
                cyc = c;
                return;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    int          cyc;
    int          n_ev;
    int          ev_kind [0:5];
    int          ev_cyc  [0:5];
    logic        seen_done;
    logic [31:0] exp_stall;

    initial begin
        rst         = 1'b0;
        auto_mem    = 1'b0;
        man_ready   = 1'b0;
        man_rdata   = 32'd0;
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'd0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'd0;
        bus.d_wdata = 32'd0;
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        mem[2] = 32'h0000_0013;              // instruction at 0x8

        // ---- Reset state ----------------------------------------------------
        repeat (3) tick();
        check("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_we",    {31'd0, bus.mem_we},  32'd0);
        check("rst_mem_addr",  bus.mem_addr,         32'd0);
        check("rst_mem_wdata", bus.mem_wdata,        32'd0);
        check("rst_i_done",    {31'd0, bus.i_done},  32'd0);
        check("rst_d_done",    {31'd0, bus.d_done},  32'd0);
        check("rst_i_rdata",   bus.i_rdata,          32'd0);
        check("rst_d_rdata",   bus.d_rdata,          32'd0);
        rst = 1'b1;
        tick();

        // ---- Single fetch, ready in cycle 2 ---------------------------------
        bus.i_req  = 1'b1;                   // cycle 0
        bus.i_addr = 32'h0000_0004;
        tick();                              // cycle 1
        check("f_mem_req_c1",  {31'd0, bus.mem_req}, 32'd1);
        check("f_mem_addr_c1", bus.mem_addr,         32'h0000_0004);
        check("f_mem_we_c1",   {31'd0, bus.mem_we},  32'd0);
        check("f_i_done_c1",   {31'd0, bus.i_done},  32'd0);
        tick();                              // cycle 2
        check("f_mem_req_c2",  {31'd0, bus.mem_req}, 32'd1);
        man_ready = 1'b1;
        man_rdata = 32'h0050_0093;
        tick();                              // cycle 3
        man_ready = 1'b0;
        check("f_i_done_c3",   {31'd0, bus.i_done},  32'd1);
        check("f_i_rdata_c3",  bus.i_rdata,          32'h0050_0093);
        check("f_d_done_c3",   {31'd0, bus.d_done},  32'd0);
        check("f_mem_req_c3",  {31'd0, bus.mem_req}, 32'd0);
        bus.i_req = 1'b0;
        tick();                              // cycle 4, back in IDLE
        check("f_i_done_c4",   {31'd0, bus.i_done},  32'd0);
`ifdef ARB_PERF_EN
        exp_stall = 32'd3;                   // i_req high in cycles 0..2
`else
        exp_stall = 32'd0;
`endif
        check("f_i_stall",     bus.i_stall_cnt,      exp_stall);

        // mem_ready while IDLE must be ignored
        man_ready = 1'b1;
        man_rdata = 32'hBAD0_BAD0;
        tick();
        man_ready = 1'b0;
        tick();
        check("idle_rdy_req",   {31'd0, bus.mem_req}, 32'd0);
        check("idle_rdy_done",  {30'd0, bus.i_done, bus.d_done}, 32'd0);
        check("idle_rdy_rdata", bus.i_rdata,          32'h0050_0093);

        // ---- Store then load ------------------------------------------------
        auto_mem    = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0100;
        bus.d_wdata = 32'hDEAD_BEEF;
        tick();                              // cycle 1, BUSY_D
        check("st_mem_we",    {31'd0, bus.mem_we}, 32'd1);
        check("st_mem_wdata", bus.mem_wdata,       32'hDEAD_BEEF);
        check("st_mem_addr",  bus.mem_addr,        32'h0000_0100);
        tick();                              // cycle 2, RESP
        check("st_d_done",    {31'd0, bus.d_done}, 32'd1);
        check("st_d_rdata",   bus.d_rdata,         32'd0);
        bus.d_req = 1'b0;
        tick();                              // IDLE
        bus.d_req = 1'b1;                    // load, cycle 0
        bus.d_we  = 1'b0;
        tick();
        check("ld_mem_we",    {31'd0, bus.mem_we}, 32'd0);
        tick();
        check("ld_d_done",    {31'd0, bus.d_done}, 32'd1);
        check("ld_d_rdata",   bus.d_rdata,         32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        tick();

        // ---- Contention: D first, then I ------------------------------------
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0008;
        bus.d_req  = 1'b1;
        n_ev = 0;
        for (int c = 1; c <= 20 && n_ev < 2; c++) begin
            tick();
            if (c == 1) check("ct_first_addr", bus.mem_addr, 32'h0000_0100);
            if (bus.d_done) begin
                ev_kind[n_ev] = 1; ev_cyc[n_ev] = c; n_ev++;
                bus.d_req = 1'b0;
            end
            if (bus.i_done) begin
                ev_kind[n_ev] = 2; ev_cyc[n_ev] = c; n_ev++;
                bus.i_req = 1'b0;
            end
        end
        check("ct_events",  n_ev,       2);
        check("ct_d_cycle", ev_cyc[0],  2);
        check("ct_d_kind",  ev_kind[0], 1);
        check("ct_i_cycle", ev_cyc[1],  5);
        check("ct_i_kind",  ev_kind[1], 2);
        check("ct_i_rdata", bus.i_rdata, 32'h0000_0013);
        tick();

        // ---- Starvation: streak limit forces I ------------------------------
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        n_ev = 0;
        for (int c = 1; c <= 40 && n_ev < 6; c++) begin
            tick();
            bus.i_req = 1'b1;
            bus.d_req = 1'b1;
            if (bus.d_done) begin
                ev_kind[n_ev] = 1; ev_cyc[n_ev] = c; n_ev++;
                bus.d_req = 1'b0;
            end else if (bus.i_done) begin
                ev_kind[n_ev] = 2; ev_cyc[n_ev] = c; n_ev++;
                bus.i_req = 1'b0;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check("sv_events", n_ev, 6);
        check("sv_kind0", ev_kind[0], 1);
        check("sv_kind1", ev_kind[1], 1);
        check("sv_kind2", ev_kind[2], 1);
        check("sv_kind3", ev_kind[3], 1);
        check("sv_kind4", ev_kind[4], 2);
        check("sv_kind5", ev_kind[5], 1);
        check("sv_i_cycle",     ev_cyc[4], 14);
        check("sv_next_d_cyc",  ev_cyc[5], 17);
        repeat (2) tick();

        // ---- Wait states then reset mid-transaction -------------------------
        auto_mem   = 1'b0;
        man_ready  = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0020;
        seen_done  = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (bus.i_done) seen_done = 1'b1;
        end
        check("ws_mem_req",  {31'd0, bus.mem_req}, 32'd1);
        check("ws_mem_addr", bus.mem_addr,         32'h0000_0020);
        check("ws_no_done",  {31'd0, seen_done},   32'd0);
        #2;
        rst = 1'b0;                          // mid-cycle, away from any edge
        #1;
        check("ar_mem_req",  {31'd0, bus.mem_req}, 32'd0);
        check("ar_mem_addr", bus.mem_addr,         32'd0);
        check("ar_i_done",   {31'd0, bus.i_done},  32'd0);
        check("ar_d_rdata",  bus.d_rdata,          32'd0);
        check("ar_i_rdata",  bus.i_rdata,          32'd0);
        bus.i_req = 1'b0;
        tick();
        check("ar_hold_done", {31'd0, bus.i_done}, 32'd0);
        rst = 1'b1;
        tick();

        // ---- Normal fetch after reset ---------------------------------------
        auto_mem   = 1'b1;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0008;
        wait_done(1'b0, 10, cyc);
        check("pr_i_cycle", cyc,         2);
        check("pr_i_rdata", bus.i_rdata, 32'h0000_0013);
        bus.i_req = 1'b0;
        tick();
`ifdef ARB_PERF_EN
        exp_stall = 32'd2;                   // i_req high in cycles 0..1
`else
        exp_stall = 32'd0;
`endif
        check("pr_i_stall", bus.i_stall_cnt, exp_stall);
        check("pr_d_stall", bus.d_stall_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
